// File: rtl/toggle_counter.sv
// Loadable, enable-gated N-bit counter built from a chain of toggle stages, with a cascadable terminal count.
// Build option: TOGGLE_CNT_UPDOWN_EN adds the dir_i port and down counting (default build is up-only).
module toggle_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
`ifdef TOGGLE_CNT_UPDOWN_EN
   input  logic             dir_i,
`endif
   output logic [WIDTH-1:0] q_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] chain_bits;
   logic [WIDTH:0]   tog;

`ifdef TOGGLE_CNT_UPDOWN_EN
   // Counting down propagates through stages that sit at zero instead of one.
   assign chain_bits = dir_i ? q_q : ~q_q;
`else
   assign chain_bits = q_q;
`endif

   assign tog[0] = en_i;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      assign tog[i+1] = tog[i] & chain_bits[i];
   end

   assign q_d = q_q ^ tog[WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         q_q <= '0;
      end else if (load_i) begin
         q_q <= d_i;
      end else begin
         q_q <= q_d;
      end
   end

   // The carry out of the top stage is the terminal count; it is suppressed on
   // load and reset cycles so a cascaded block never steps on those edges.
   assign tc_o = tog[WIDTH] & ~load_i & rst_n_i;
   assign q_o  = q_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter: two 4-bit instances cascaded (lower tc_o drives upper en_i),
// checked against an 8-bit reference count through a scoreboard queue.
module tb_toggle_counter;

   logic       clk = 1'b0;
   logic       rst_n, en, load, dir;
   logic [3:0] d;
   logic [3:0] q_lo, q_hi;
   logic       tc_lo, tc_hi;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m8;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   toggle_counter #(.WIDTH(4)) u_lo (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (en),
      .load_i  (load),
      .d_i     (d),
`ifdef TOGGLE_CNT_UPDOWN_EN
      .dir_i   (dir),
`endif
      .q_o     (q_lo),
      .tc_o    (tc_lo)
   );

   toggle_counter #(.WIDTH(4)) u_hi (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (tc_lo),
      .load_i  (1'b0),
      .d_i     (4'h0),
`ifdef TOGGLE_CNT_UPDOWN_EN
      .dir_i   (dir),
`endif
      .q_o     (q_hi),
      .tc_o    (tc_hi)
   );

   // One clock cycle: drive inputs, check combinational TC, predict, clock, check Q.
   task automatic step(input logic r, input logic e, input logic l,
                       input logic [3:0] dv, input logic up);
      logic       exp_tc_lo, exp_tc_hi;
      logic [7:0] got, exp;
      rst_n = r; en = e; load = l; d = dv;
`ifdef TOGGLE_CNT_UPDOWN_EN
      dir = up;
`else
      dir = 1'b1;
`endif
      #1;
      exp_tc_lo = r & ~l & e & (dir ? (m8[3:0] == 4'hF) : (m8[3:0] == 4'h0));
      exp_tc_hi = exp_tc_lo & (dir ? (m8[7:4] == 4'hF) : (m8[7:4] == 4'h0));
      n_tests++;
      assert (tc_lo === exp_tc_lo) else begin
         n_fail++;
         $error("FAIL tc_lo observed=%b expected=%b (model q=%h)", tc_lo, exp_tc_lo, m8);
      end
      n_tests++;
      assert (tc_hi === exp_tc_hi) else begin
         n_fail++;
         $error("FAIL tc_hi observed=%b expected=%b (model q=%h)", tc_hi, exp_tc_hi, m8);
      end
      if (!r)        m8 = 8'h00;
      else if (l)    m8[3:0] = dv;
      else if (e)    m8 = dir ? m8 + 8'd1 : m8 - 8'd1;
      sb_q.push_back(m8);
      @(posedge clk);
      #1;
      got = {q_hi, q_lo};
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard empty observed=%h expected=<entry>", got);
      end else begin
         exp = sb_q.pop_front();
         assert (got === exp) else begin
            n_fail++;
            $error("FAIL q observed=%h expected=%h", got, exp);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; load = 1'b0; d = 4'h0; dir = 1'b1;
      m8 = 8'h00;
      @(negedge clk);

      // Reset dominates load and enable.
      step(1'b0, 1'b1, 1'b1, 4'hA, 1'b1);
      step(1'b0, 1'b1, 1'b1, 4'hA, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'hA, 1'b1);

      // Up wrap from zero over 17 edges.
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);

`ifdef TOGGLE_CNT_UPDOWN_EN
      // Down wrap after loading 2; also a direction flip mid-count.
      step(1'b1, 1'b0, 1'b1, 4'h2, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
`endif

      // Load wins over enable; TC low on load cycles even at F.
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'hC, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'hF, 1'b1);

      // Lower at F with enable low: upper must not move.
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);

      // Random enable pattern on the cascade.
      for (int i = 0; i < 80; i++)
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'h0, 1'b1);

      // Reset mid-count at 9 discards a pending load, then counting resumes.
      step(1'b1, 1'b0, 1'b1, 4'h9, 1'b1);
      step(1'b0, 1'b1, 1'b1, 4'h7, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/toggle_counter.md
# toggle_counter

Synchronous N-bit binary counter built as a chain of toggle stages, where stage i toggles when all lower stages are at their terminal value. It sits directly downstream of the single-bit toggle flip-flop in the lab datapath. It extends that one-bit toggling element into a loadable, enable-gated multi-bit counter with a terminal-count output for cascading. All state updates occur on the rising edge of one clock.

## Interface
- WIDTH, default 4: number of counter bits (toggle stages); legal range 2–16.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-low; sampled on the rising CLK edge.
- EN  input  1  count enable; when high and no load, the counter advances one step per cycle.
- LOAD  input  1  synchronous parallel load of D.
- D  input  WIDTH  load value.
- DIR  input  1  count direction; 1 = up, 0 = down. Present only with TOGGLE_CNT_UPDOWN_EN.
- Q  output  WIDTH  registered count value.
- TC  output  1  terminal count, combinational: high when EN=1, LOAD=0, and Q is at the wrap value for the current direction.

## Operation
- Per-edge priority: RST low > LOAD high > EN high > hold.
  - RST=0: Q ← 0.
  - LOAD=1: Q ← D, regardless of EN.
  - EN=1: Q advances one step.
  - Otherwise Q holds.
- Toggle structure, counting up:
  - T[0] = EN.
  - T[i] = EN & Q[0] & … & Q[i-1].
  - Q[i] ← Q[i] ^ T[i].
- Counting down uses the same structure with the complement of the Q bits in the AND chain.
- Arithmetic is modulo 2^WIDTH; no saturation.
  - Up: all-ones → 0.
  - Down: 0 → all-ones.
- TC terminal values: all-ones when counting up, zero when counting down.
  - TC equals the toggle term that would carry into a hypothetical stage WIDTH.
  - Cascading: connect this block's TC to the next block's EN.
- TC is forced low while LOAD=1 or RST=0, so a cascaded stage never advances on a load or reset cycle.
- Hold cycles (EN=0, LOAD=0) change nothing, and TC stays low.

## Timing
- Reset value: Q = 0. TC = 0 while RST=0.
- Latency:
  - A change on EN, LOAD or D is visible on Q one edge later.
  - TC responds combinationally to EN, LOAD, DIR and Q within the same cycle.
- RST deasserting (going high) at an edge: that edge still applies the reset. Counting starts at the first edge where RST=1 and EN=1.
- RST asserted mid-count: Q is 0 after that edge, and any pending load is discarded.
- LOAD and EN high in the same cycle: the load wins and Q = D; the count step is lost.
- DIR changed mid-count: takes effect on the next edge, with no extra delay cycle.
- No combinational path from D to any output.

## Configuration
- TOGGLE_CNT_UPDOWN_EN defined:
  - The DIR port exists.
  - Up and down counting operate as described above.
- TOGGLE_CNT_UPDOWN_EN undefined:
  - The DIR port is absent.
  - The counter is up-only.
  - TC is high only at all-ones with EN=1 and LOAD=0.
  - Gate count drops by the down-chain and its direction mux.

## Test plan
- Reset (WIDTH=4): hold RST=0 for 2 edges with EN=1 and LOAD=1, D=4'hA -> Q=0 and TC=0 throughout. Release RST -> Q=1 one edge later.
- Up wrap: EN=1, DIR=1, run from 0 for 17 edges.
  - Q steps 0,1,…,F,0,1.
  - TC high only during the cycle with Q=F.
- Down wrap (macro defined): load D=4'h2, then EN=1, DIR=0 -> Q = 2,1,0,F,E. TC high only during the cycle with Q=0.
- Load priority: at Q=5 with EN=1, LOAD=1, D=4'hC -> Q=C next edge (not 6 or D). TC stays 0 during the load cycle, even when D or Q is F.
- Hold and cascade: two instances, lower TC driving upper EN.
  - Lower EN toggled randomly; the 8-bit concatenation counts only on EN-high edges.
  - Lower at F with EN=0 -> upper does not advance.
- Reset mid-count: at Q=9, DIR=1, pulse RST=0 for one edge -> Q=0 next edge, then resume counting 1,2,3.
